// File: rtl/piso_serializer_pkg.sv
// piso_pkg: state encodings and counter-width helper for the PISO serializer
package piso_pkg;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SHIFT = 2'd1, ST_PARITY = 2'd2} state_t;
  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction
endpackage

// File: rtl/piso_serializer_if.sv
// piso_serializer_if: load handshake and serial output bundle
interface piso_serializer_if #(parameter int WIDTH = 8);
  logic load_valid, load_ready, sout, sout_valid, frame_start, done;
  logic [WIDTH-1:0] din;
  modport master(output load_valid, din, input load_ready, sout, sout_valid, frame_start, done);
  modport slave(input load_valid, din, output load_ready, sout, sout_valid, frame_start, done);
endinterface

// File: rtl/piso_bit_counter.sv
// piso_bit_counter: bit index of the frame bit on sout, terminal flag at WIDTH-1
module piso_bit_counter #(parameter int WIDTH = 8, parameter int CW = 4) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] cnt,
  output logic          tc
);
  assign tc = cnt == CW'(WIDTH - 1);
  always_ff @(posedge clk)
    if (!rst_n || clr) cnt <= '0;
    else if (en) cnt <= cnt + 1'b1;
endmodule

// File: rtl/piso_serializer.sv
// piso_serializer: valid/ready loaded parallel-to-serial transmitter
// PISO_PARITY_EN adds a trailing even-parity bit to every frame
module piso_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input logic              clk,
  input logic              rst_n,
  piso_serializer_if.slave bus
);
  localparam int CW = cnt_w(WIDTH);
`ifdef PISO_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  state_t           state;
  logic [WIDTH-1:0] sr, d_sh, s_sh;
  logic [CW-1:0]    cnt;
  logic             par, tc, last, accept;
  assign d_sh = MSB_FIRST ? bus.din << 1 : bus.din >> 1;
  assign s_sh = MSB_FIRST ? sr << 1 : sr >> 1;
  assign last = PAR ? state == ST_PARITY : state == ST_SHIFT && tc;
  assign bus.load_ready = rst_n && (state == ST_IDLE || last);
  assign accept = bus.load_valid && bus.load_ready;
  piso_bit_counter #(.WIDTH(WIDTH), .CW(CW)) u_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (accept),
    .en   (state == ST_SHIFT && !tc),
    .cnt  (cnt),
    .tc   (tc)
  );
  // sout always shows the bit indexed by cnt; sr holds the bits still to come
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= ST_IDLE;
      sr <= '0;
      par <= 1'b0;
      bus.sout <= 1'b0;
      bus.sout_valid <= 1'b0;
      bus.frame_start <= 1'b0;
      bus.done <= 1'b0;
    end else if (accept) begin
      state <= ST_SHIFT;
      sr <= d_sh;
      par <= ^bus.din;
      bus.sout <= MSB_FIRST ? bus.din[WIDTH-1] : bus.din[0];
      bus.sout_valid <= 1'b1;
      bus.frame_start <= 1'b1;
      bus.done <= 1'b0;
    end else if (state == ST_SHIFT && !tc) begin
      sr <= s_sh;
      bus.sout <= MSB_FIRST ? sr[WIDTH-1] : sr[0];
      bus.frame_start <= 1'b0;
      bus.done <= !PAR && cnt == CW'(WIDTH - 2);
    end else if (PAR && state == ST_SHIFT) begin
      state <= ST_PARITY;
      bus.sout <= par;
      bus.frame_start <= 1'b0;
      bus.done <= 1'b1;
    end else begin
      state <= ST_IDLE;
      bus.sout <= 1'b0;
      bus.sout_valid <= 1'b0;
      bus.frame_start <= 1'b0;
      bus.done <= 1'b0;
    end
endmodule
